// File: rtl/eeprom_addr_ptr.sv
// EEPROM word-address pointer: multi-byte address load, then
// per-data-byte increment with page wrap (write) or array wrap (read).
module eeprom_addr_ptr #(
  parameter int ADDR_W     = 8,
  parameter int PAGE_W     = 3,
  parameter int ADDR_BYTES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     addr_start,
  input  logic                     addr_byte_vld,
  input  logic [7:0]               addr_byte,
  input  logic                     mode,
  input  logic                     inc,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [ADDR_W-PAGE_W-1:0] page_o,
  output logic [PAGE_W-1:0]        word_o,
  output logic                     addr_valid,
  output logic                     page_wrap,
  output logic                     array_wrap,
  output logic [PAGE_W:0]          wr_count,
  output logic                     ovf
);

  localparam int AW = ADDR_BYTES * 8;
  localparam logic [1:0] LAST = 2'(ADDR_BYTES - 1);
  localparam logic [PAGE_W:0] WMAX = {1'b1, {PAGE_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d, idx_base;
  logic [AW-1:0]     asm_q, asm_d;
  logic [AW+7:0]     asm_cat;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PAGE_W:0]   wrc_q, wrc_d;
  logic [PAGE_W-1:0] word_nx;
  logic              pw_q, pw_d;
  logic              aw_q, aw_d;
  logic              ovf_q, ovf_d;
  logic              take_byte, do_inc;
  logic              unused_bits;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    addr_d   = addr_q;
    wrc_d    = wrc_q;
    ovf_d    = ovf_q;
    pw_d     = 1'b0;
    aw_d     = 1'b0;
    idx_base = addr_start ? 2'd0 : idx_q;
    asm_cat  = {addr_start ? {AW{1'b0}} : asm_q, addr_byte};
    word_nx  = addr_q[PAGE_W-1:0] + PAGE_W'(1);
    take_byte = addr_byte_vld && (addr_start || state_q == LOAD);
    do_inc    = inc && !addr_start && state_q == READY;

    if (addr_start) begin
      state_d = LOAD;
      idx_d   = 2'd0;
      wrc_d   = '0;
      ovf_d   = 1'b0;
    end

    unique case (1'b1)
      take_byte: begin
        asm_d = asm_cat[AW-1:0];
        if (idx_base == LAST) begin
          addr_d  = asm_cat[ADDR_W-1:0];
          state_d = READY;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_base + 2'd1;
        end
      end
      do_inc && mode: begin
        addr_d = addr_q + ADDR_W'(1);
        aw_d   = &addr_q;
      end
      do_inc && !mode: begin
        // Column wraps inside the page; row is never touched.
        addr_d = {addr_q[ADDR_W-1:PAGE_W], word_nx};
        pw_d   = &addr_q[PAGE_W-1:0];
        if (wrc_q == WMAX) ovf_d = 1'b1;
        else wrc_d = wrc_q + (PAGE_W+1)'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      wrc_q   <= '0;
      ovf_q   <= 1'b0;
      pw_q    <= 1'b0;
      aw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      wrc_q   <= wrc_d;
      ovf_q   <= ovf_d;
      pw_q    <= pw_d;
      aw_q    <= aw_d;
    end
  end

  assign addr_o      = addr_q;
  assign page_o      = addr_q[ADDR_W-1:PAGE_W];
  assign word_o      = addr_q[PAGE_W-1:0];
  assign addr_valid  = (state_q == READY);
  assign page_wrap   = pw_q;
  assign array_wrap  = aw_q;
  assign wr_count    = wrc_q;
  assign ovf         = ovf_q;
  assign unused_bits = ^asm_cat;

endmodule

// File: tb/tb_eeprom_addr_ptr.sv
// Directed bench for eeprom_addr_ptr: default 1-byte instance (A)
// and a 12-bit, 2-byte-address instance (B) sharing stimulus.
module tb_eeprom_addr_ptr;

  logic       clk = 1'b0;
  logic       rst, start, vld, mode, inc;
  logic [7:0] abyte;

  logic [7:0]  a_addr;
  logic [4:0]  a_page;
  logic [2:0]  a_word;
  logic        a_vld, a_pw, a_aw, a_ovf;
  logic [3:0]  a_wrc;
  logic [11:0] b_addr;
  logic [8:0]  b_page;
  logic [2:0]  b_word;
  logic        b_vld, b_pw, b_aw, b_ovf;
  logic [3:0]  b_wrc;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    string       tag;
    bit          sel;
    logic [15:0] addr;
    logic        vld, pw, aw, ovf;
    logic [3:0]  wrc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  eeprom_addr_ptr u_a (
    .clk(clk), .rst(rst), .addr_start(start), .addr_byte_vld(vld),
    .addr_byte(abyte), .mode(mode), .inc(inc), .addr_o(a_addr),
    .page_o(a_page), .word_o(a_word), .addr_valid(a_vld),
    .page_wrap(a_pw), .array_wrap(a_aw), .wr_count(a_wrc), .ovf(a_ovf)
  );

  eeprom_addr_ptr #(.ADDR_W(12), .PAGE_W(3), .ADDR_BYTES(2)) u_b (
    .clk(clk), .rst(rst), .addr_start(start), .addr_byte_vld(vld),
    .addr_byte(abyte), .mode(mode), .inc(inc), .addr_o(b_addr),
    .page_o(b_page), .word_o(b_word), .addr_valid(b_vld),
    .page_wrap(b_pw), .array_wrap(b_aw), .wr_count(b_wrc), .ovf(b_ovf)
  );

  task automatic chk(string tag, string f, logic [15:0] o, logic [15:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s.%s observed %h expected %h", tag, f, o, e);
    end
  endtask

  task automatic compare(exp_t e);
    if (e.sel) begin
      chk(e.tag, "addr", {4'h0, b_addr}, e.addr);
      chk(e.tag, "page", {7'h0, b_page}, {7'h0, e.addr[11:3]});
      chk(e.tag, "vld", {15'h0, b_vld}, {15'h0, e.vld});
      chk(e.tag, "pw", {15'h0, b_pw}, {15'h0, e.pw});
      chk(e.tag, "aw", {15'h0, b_aw}, {15'h0, e.aw});
      chk(e.tag, "wrc", {12'h0, b_wrc}, {12'h0, e.wrc});
      chk(e.tag, "ovf", {15'h0, b_ovf}, {15'h0, e.ovf});
    end else begin
      chk(e.tag, "addr", {8'h0, a_addr}, e.addr);
      chk(e.tag, "page", {11'h0, a_page}, {11'h0, e.addr[7:3]});
      chk(e.tag, "word", {13'h0, a_word}, {13'h0, e.addr[2:0]});
      chk(e.tag, "vld", {15'h0, a_vld}, {15'h0, e.vld});
      chk(e.tag, "pw", {15'h0, a_pw}, {15'h0, e.pw});
      chk(e.tag, "aw", {15'h0, a_aw}, {15'h0, e.aw});
      chk(e.tag, "wrc", {12'h0, a_wrc}, {12'h0, e.wrc});
      chk(e.tag, "ovf", {15'h0, a_ovf}, {15'h0, e.ovf});
    end
  endtask

  task automatic step(string tag, bit sel, logic r, logic s, logic v,
                      logic [7:0] b, logic m, logic i, logic [15:0] ea,
                      logic ev, logic epw, logic eaw, logic [3:0] ew,
                      logic eo);
    exp_t e;
    rst = r; start = s; vld = v; abyte = b; mode = m; inc = i;
    e.tag = tag; e.sel = sel; e.addr = ea; e.vld = ev;
    e.pw = epw; e.aw = eaw; e.wrc = ew; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    while (sb.size() > 0) compare(sb.pop_front());
  endtask

  initial begin
    rst = 1'b1; start = 0; vld = 0; abyte = 0; mode = 0; inc = 0;
    // reset state of both instances
    step("rstA", 0, 1, 0, 0, 8'h00, 0, 0, 16'h0, 0, 0, 0, 4'd0, 0);
    step("rstB", 1, 1, 1, 1, 8'hFF, 1, 1, 16'h0, 0, 0, 0, 4'd0, 0);

    // two-byte load with an inc between the bytes
    step("b_byte0", 1, 0, 1, 1, 8'hA5, 0, 0, 16'h0, 0, 0, 0, 4'd0, 0);
    step("b_incLd", 1, 0, 0, 0, 8'h00, 0, 1, 16'h0, 0, 0, 0, 4'd0, 0);
    step("b_byte1", 1, 0, 0, 1, 8'h67, 0, 0, 16'h567, 1, 0, 0, 4'd0, 0);
    step("b_inc", 1, 0, 0, 0, 8'h00, 0, 1, 16'h560, 1, 1, 0, 4'd1, 0);
    // reset mid-load, then inc and stray byte in IDLE
    step("b_part", 1, 0, 1, 1, 8'h12, 0, 0, 16'h560, 0, 0, 0, 4'd0, 0);
    step("b_rst", 1, 1, 0, 0, 8'h00, 0, 0, 16'h0, 0, 0, 0, 4'd0, 0);
    step("b_idInc", 1, 0, 0, 0, 8'h00, 1, 1, 16'h0, 0, 0, 0, 4'd0, 0);
    step("b_idByte", 1, 0, 0, 1, 8'h34, 0, 0, 16'h0, 0, 0, 0, 4'd0, 0);
    step("b_re0", 1, 0, 1, 1, 8'h0A, 0, 0, 16'h0, 0, 0, 0, 4'd0, 0);
    step("b_re1", 1, 0, 0, 1, 8'hBC, 0, 0, 16'hABC, 1, 0, 0, 4'd0, 0);
    step("b_rdInc", 1, 0, 0, 0, 8'h00, 1, 1, 16'hABD, 1, 0, 0, 4'd0, 0);

    step("a_rst", 0, 1, 0, 0, 8'h00, 0, 0, 16'h0, 0, 0, 0, 4'd0, 0);
    // write mode page wrap
    step("a_ld3E", 0, 0, 1, 1, 8'h3E, 0, 0, 16'h3E, 1, 0, 0, 4'd0, 0);
    step("a_w1", 0, 0, 0, 0, 8'h00, 0, 1, 16'h3F, 1, 0, 0, 4'd1, 0);
    step("a_w2", 0, 0, 0, 0, 8'h00, 0, 1, 16'h38, 1, 1, 0, 4'd2, 0);
    step("a_w3", 0, 0, 0, 0, 8'h00, 0, 1, 16'h39, 1, 0, 0, 4'd3, 0);
    step("a_hold", 0, 0, 0, 0, 8'h00, 0, 0, 16'h39, 1, 0, 0, 4'd3, 0);

    // read mode array wrap
    step("a_ldFF", 0, 0, 1, 1, 8'hFF, 1, 0, 16'hFF, 1, 0, 0, 4'd0, 0);
    step("a_r1", 0, 0, 0, 0, 8'h00, 1, 1, 16'h00, 1, 0, 1, 4'd0, 0);
    step("a_r1end", 0, 0, 0, 0, 8'h00, 1, 0, 16'h00, 1, 0, 0, 4'd0, 0);

    // write count saturation and overflow
    step("a_ld10", 0, 0, 1, 1, 8'h10, 0, 0, 16'h10, 1, 0, 0, 4'd0, 0);
    for (int k = 1; k <= 9; k++) begin
      step($sformatf("a_wc%0d", k), 0, 0, 0, 0, 8'h00, 0, 1,
           16'h10 + 16'(k % 8), 1, (k == 8), 0,
           (k > 8) ? 4'd8 : 4'(k), (k == 9));
    end
    step("a_rdKeep", 0, 0, 0, 0, 8'h00, 1, 1, 16'h12, 1, 0, 0, 4'd8, 1);

    // start beats inc; inc and stray bytes ignored outside LOAD
    step("a_stInc", 0, 0, 1, 0, 8'h00, 0, 1, 16'h12, 0, 0, 0, 4'd0, 0);
    step("a_ldInc", 0, 0, 0, 0, 8'h00, 1, 1, 16'h12, 0, 0, 0, 4'd0, 0);
    step("a_ld20", 0, 0, 0, 1, 8'h20, 0, 0, 16'h20, 1, 0, 0, 4'd0, 0);
    step("a_rdyByte", 0, 0, 0, 1, 8'h55, 0, 0, 16'h20, 1, 0, 0, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
